pipe_ctrl_unit: RTL and testbench

//  Central sequencing controller for the 5-stage pipelined core. Generates all

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_unit_fwd_sel.sv | 36 +++
 rtl/pipe_ctrl_unit.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline control unit: the sequencing
//             FSM state encoding and the EX operand forwarding select codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM ALU result

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_unit_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_sel
//  Purpose  : Forwarding select for one EX source operand. MEM outranks WB
//             because it holds the younger write; x0 is never forwarded.
//  Ports    : rs        in  AW  source register of the EX instruction
//             rdM, rdW  in  AW  destination registers in MEM / WB
//             RegWriteM in  1   MEM write enable
//             RegWriteW in  1   WB write enable
//             fwd       out 2   operand select (FWD_RF / FWD_WB / FWD_MEM)
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rdM,
  input  logic [AW-1:0] rdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  output logic [1:0]    fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (RegWriteM && (rdM != '0) && (rdM == rs)) begin
      fwd = FWD_MEM;
    end else if (RegWriteW && (rdW != '0) && (rdW == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Purpose  : Sequencing controller for the 5-stage core. Produces stall and
//             flush controls for IF/ID/EX/MEM, the EX forwarding selects, holds
//             EX for the duration of a fixed-latency multicycle op, resolves
//             load-use hazards and taken-branch redirects, and counts stalls.
//  Ports    : clk, rst                    clock, synchronous active-high reset
//             rs1D, rs2D                  ID source registers
//             rs1E, rs2E, rdE             EX source / destination registers
//             rdM, rdW                    MEM / WB destination registers
//             RegWriteM, RegWriteW        MEM / WB write enables
//             MemReadE, PCSrcE, McStartE  EX load / taken branch / multicycle op
//             StallF, StallD, StallE      hold PC / IF-ID / ID-EX
//             FlushD, FlushE, FlushM      bubble IF-ID / ID-EX / EX-MEM
//             FwdAE, FwdBE                EX operand selects
//             McDoneE                     multicycle result valid pulse
//             StallCnt                    saturating count of StallF cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int AW     = 5,
  parameter int MC_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1D,
  input  logic [AW-1:0] rs2D,
  input  logic [AW-1:0] rs1E,
  input  logic [AW-1:0] rs2E,
  input  logic [AW-1:0] rdE,
  input  logic [AW-1:0] rdM,
  input  logic [AW-1:0] rdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemReadE,
  input  logic          PCSrcE,
  input  logic          McStartE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic [1:0]    FwdAE,
  output logic [1:0]    FwdBE,
  output logic          McDoneE,
  output logic [15:0]   StallCnt
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  // The start cycle and the done cycle are both part of the EX occupancy, so
  // the counter covers only the cycles in between.
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(MC_LAT - 2);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [15:0]   r_stall_cnt;
  logic          w_lw_stall;

  fwd_sel #(.AW(AW)) u_fwd_a (
    .rs        (rs1E),
    .rdM       (rdM),
    .rdW       (rdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd       (FwdAE)
  );

  fwd_sel #(.AW(AW)) u_fwd_b (
    .rs        (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd       (FwdBE)
  );

  assign w_lw_stall = MemReadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushM       = 1'b0;
    McDoneE      = 1'b0;
    case (r_state)
      RUN: begin
        if (PCSrcE) begin
          // Redirect wins: a multicycle op in EX is on the wrong path.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (McStartE) begin
          StallF       = 1'b1;
          StallD       = 1'b1;
          StallE       = 1'b1;
          FlushM       = 1'b1;
          w_cnt_next   = C_CNT_LOAD;
          w_next_state = MC_WAIT;
        end else if (w_lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MC_WAIT: begin
        // The EX instruction is the multicycle op itself, so hazards reported
        // against EX are not meaningful here and are ignored.
        if (r_cnt != '0) begin
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          FlushM     = 1'b1;
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          McDoneE      = 1'b1;
          w_next_state = RUN;
        end
      end
      default: begin
        w_next_state = RUN;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (StallF && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign StallCnt = r_stall_cnt;

endmodule : pipe_ctrl_unit
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl_unit
//  Purpose  : Self-checking bench for pipe_ctrl_unit. Directed vectors push
//             hand-computed expected outputs into a queue; a monitor on the
//             falling edge pops and compares them against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          RegWriteM, RegWriteW, MemReadE, PCSrcE, McStartE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, McDoneE;
  logic [1:0]    FwdAE, FwdBE;
  logic [15:0]   StallCnt;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.AW(AW), .MC_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FwdAE(FwdAE), .FwdBE(FwdBE), .McDoneE(McDoneE), .StallCnt(StallCnt)
  );

  // ctl bit order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,McDoneE,FwdAE,FwdBE}
  typedef struct {
    string       name;
    logic [10:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  logic        samp = 1'b0;
  logic [15:0] exp_cnt = 16'd0;
  int          n_cmp = 0;
  int          n_fail = 0;

  localparam logic [10:0] C_NONE  = 11'b000_000_0_00_00;
  localparam logic [10:0] C_LW    = 11'b110_010_0_00_00;
  localparam logic [10:0] C_BR    = 11'b000_110_0_00_00;
  localparam logic [10:0] C_MC    = 11'b111_001_0_00_00;
  localparam logic [10:0] C_DONE  = 11'b000_000_1_00_00;

  // Monitor: the DUT outputs are combinational, so each issued vector is a
  // presented result, taken mid-cycle.
  always @(negedge clk) begin
    if (samp) begin
      logic [10:0] act;
      exp_t        e;
      act = {StallF, StallD, StallE, FlushD, FlushE, FlushM, McDoneE, FwdAE, FwdBE};
      n_cmp++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got ctl=%b cnt=%h, required an expected entry", act, StallCnt);
      end else begin
        e = sbq.pop_front();
        if (act !== e.ctl || StallCnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got ctl=%b cnt=%h, required ctl=%b cnt=%h",
                   e.name, act, StallCnt, e.ctl, e.cnt);
        end
      end
    end
  end

  // Inputs are applied just after a rising edge before calling this; one
  // cycle of the vector is checked and the expected stall count advanced.
  task automatic cycle(input string nm, input logic [10:0] ctl);
    exp_t e;
    e.name = nm;
    e.ctl  = ctl;
    e.cnt  = exp_cnt;
    sbq.push_back(e);
    samp = 1'b1;
    @(posedge clk);
    #1;
    samp = 1'b0;
    if (ctl[10] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReadE = 1'b0; PCSrcE = 1'b0; McStartE = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("reset_state", C_NONE);

    // Forwarding
    rs1E = 5'd5; rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1;
    cycle("fwd_mem_prio", 11'b000_000_0_10_00);
    RegWriteM = 1'b0;
    cycle("fwd_wb", 11'b000_000_0_01_00);
    rdM = 5'd0; rdW = 5'd0; RegWriteM = 1'b1; rs1E = 5'd0; rs2E = 5'd0;
    cycle("fwd_x0", C_NONE);
    rs1E = 5'd3; rs2E = 5'd9; rdM = 5'd3; rdW = 5'd9; RegWriteW = 1'b1;
    cycle("fwd_both", 11'b000_000_0_10_01);
    clear_inputs();

    // Load-use
    MemReadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    cycle("lw_rs2", C_LW);
    clear_inputs();
    cycle("lw_released", C_NONE);
    MemReadE = 1'b1; rdE = 5'd12; rs1D = 5'd12;
    cycle("lw_rs1", C_LW);
    rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
    cycle("lw_x0", C_NONE);
    clear_inputs();

    // Branch beats load-use
    MemReadE = 1'b1; rdE = 5'd7; rs2D = 5'd7; PCSrcE = 1'b1;
    cycle("br_over_lw", C_BR);
    clear_inputs();
    cycle("br_no_cnt", C_NONE);

    // Multicycle op, t..t+4
    McStartE = 1'b1;
    cycle("mc_t0", C_MC);
    McStartE = 1'b0; PCSrcE = 1'b1;
    cycle("mc_t1_br_ign", C_MC);
    PCSrcE = 1'b0; MemReadE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
    cycle("mc_t2_lw_ign", C_MC);
    PCSrcE = 1'b1;
    cycle("mc_t3_done", C_DONE);
    clear_inputs();
    cycle("mc_t4_after", C_NONE);

    // Reset during MC_WAIT
    McStartE = 1'b1;
    cycle("mcr_t0", C_MC);
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 16'd0;
    cycle("mcr_t2_run", C_NONE);
    cycle("mcr_t3_nodone", C_NONE);
    cycle("mcr_t4_nodone", C_NONE);

    // Saturation: hold a load-use hazard until the counter reaches FFFE
    MemReadE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
    repeat (65534) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFE;
    cycle("sat_fffe", C_LW);
    cycle("sat_ffff", C_LW);
    cycle("sat_hold", C_LW);
    clear_inputs();
    cycle("sat_final", C_NONE);

    @(posedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pipe_ctrl_unit
`default_nettype wire
